// File: rtl/fp_cons.sv
// Shared FP constants: CSR addresses, access ops, rounding modes, exception
// flag positions, and the read-modify-write helper used by the CSR file.
package fp_cons;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned RM_W   = 3;

    localparam logic [ADDR_W-1:0] ADDR_FFLAGS = 12'h001;
    localparam logic [ADDR_W-1:0] ADDR_FRM    = 12'h002;
    localparam logic [ADDR_W-1:0] ADDR_FCSR   = 12'h003;

    typedef enum logic [OP_W-1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    // 101 and 110 are reserved; 111 selects the dynamic mode held in frm.
    typedef enum logic [RM_W-1:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100,
        RM_DYN = 3'b111
    } rm_e;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    // Every architecturally defined exception flag bit.
    localparam logic [FLAG_W-1:0] FLAG_MASK =
        FLAG_W'((1 << FLAG_NV) | (1 << FLAG_DZ) | (1 << FLAG_OF) |
                (1 << FLAG_UF) | (1 << FLAG_NX));

    // Next value of a CSR field for a given access type.
    function automatic logic [7:0] csr_apply(input logic [OP_W-1:0] op,
                                             input logic [7:0] old,
                                             input logic [7:0] opnd);
        logic [7:0] res;
        res = old;
        case (op)
            CSR_WRITE: res = opnd;
            CSR_SET:   res = old | opnd;
            CSR_CLEAR: res = old & ~opnd;
            default:   res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_csr_if.sv
// CSR access bus between a requester (master) and the FP CSR file (slave).
// Request: csr_valid, csr_addr, csr_op, csr_wdata.
// Response: csr_rdata, csr_rvalid, csr_illegal (one cycle after request).
interface fp_csr_if #(
    parameter int unsigned XLEN = 32
);
    import fp_cons::*;

    logic              csr_valid;
    logic [ADDR_W-1:0] csr_addr;
    logic [OP_W-1:0]   csr_op;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;
    logic              csr_rvalid;
    logic              csr_illegal;

    modport master (
        output csr_valid, csr_addr, csr_op, csr_wdata,
        input  csr_rdata, csr_rvalid, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_addr, csr_op, csr_wdata,
        output csr_rdata, csr_rvalid, csr_illegal
    );

endinterface

// File: rtl/fp_rm_resolve.sv
// Combinational rounding-mode resolution.
// rm_in      : instruction rm field (111 = dynamic)
// frm        : current registered frm
// rm_out     : effective rounding mode
// rm_illegal : effective mode is reserved (101, 110, 111)
module fp_rm_resolve
    import fp_cons::*;
(
    input  logic [RM_W-1:0] rm_in,
    input  logic [RM_W-1:0] frm,
    output logic [RM_W-1:0] rm_out,
    output logic            rm_illegal
);

    assign rm_out     = (rm_in == RM_DYN) ? frm : rm_in;
    // Everything above RMM is either reserved or an unresolved DYN in frm.
    assign rm_illegal = (rm_out > RM_RMM);

endmodule

// File: rtl/fp_csr.sv
// FP control/status register file: fflags, frm and the fcsr alias.
// clock, reset     : rising-edge clock, async active-high reset
// csr              : CSR access bus (slave side), registered read response
// flag_valid/data  : per-port retire strobes and exception flags to accumulate
// rm_in/rm_out     : instruction rounding mode and resolved mode (comb)
// rm_illegal       : resolved mode is reserved (comb)
// dirty/dirty_clear: sticky "FP state modified" bit and its clear
module fp_csr
    import fp_cons::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned XLEN   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    fp_csr_if.slave                  csr,
    input  logic [NPORTS-1:0]        flag_valid,
    input  logic [NPORTS*FLAG_W-1:0] flag_data,
    input  logic [RM_W-1:0]          rm_in,
    output logic [RM_W-1:0]          rm_out,
    output logic                     rm_illegal,
    output logic                     dirty,
    input  logic                     dirty_clear
);

    logic [FLAG_W-1:0] fflags;
    logic [RM_W-1:0]   frm;
    logic [FLAG_W-1:0] flag_acc;
    logic [FLAG_W-1:0] fflags_csr;
    logic [FLAG_W-1:0] fflags_next;
    logic [RM_W-1:0]   frm_next;
    logic [RM_W-1:0]   frm_opnd;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   read_val;
    logic              hit_fflags;
    logic              hit_frm;
    logic              hit_fcsr;
    logic              legal;
    logic              wr_fflags;
    logic              wr_frm;
    logic              unused_wdata;

    assign wdata        = csr.csr_wdata;
    assign unused_wdata = ^wdata[XLEN-1:8];

    // OR together the flags of every retiring port.
    always_comb begin
        flag_acc = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (flag_valid[i]) begin
                flag_acc = flag_acc | flag_data[i*FLAG_W +: FLAG_W];
            end
        end
        flag_acc = flag_acc & FLAG_MASK;
    end

    assign hit_fflags = (csr.csr_addr == ADDR_FFLAGS);
    assign hit_frm    = (csr.csr_addr == ADDR_FRM);
    assign hit_fcsr   = (csr.csr_addr == ADDR_FCSR);
    assign legal      = hit_fflags | hit_frm | hit_fcsr;
    assign wr_fflags  = csr.csr_valid & (hit_fflags | hit_fcsr);
    assign wr_frm     = csr.csr_valid & (hit_frm | hit_fcsr);
    assign frm_opnd   = hit_fcsr ? wdata[7:5] : wdata[2:0];

    // Next state and pre-update read value.
    always_comb begin
        fflags_csr = fflags;
        frm_next   = frm;
        read_val   = '0;
        if (wr_fflags) begin
            fflags_csr = FLAG_W'(csr_apply(csr.csr_op, 8'(fflags), 8'(wdata[4:0])));
        end
        if (wr_frm) begin
            frm_next = RM_W'(csr_apply(csr.csr_op, 8'(frm), 8'(frm_opnd)));
        end
        // Retired flags are OR-ed after the CSR op so a clear cannot drop them.
        fflags_next = fflags_csr | flag_acc;
        if (hit_fflags) begin
            read_val = XLEN'(fflags);
        end else if (hit_frm) begin
            read_val = XLEN'(frm);
        end else if (hit_fcsr) begin
            read_val = XLEN'({frm, fflags});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fflags          <= '0;
            frm             <= '0;
            dirty           <= 1'b0;
            csr.csr_rdata   <= '0;
            csr.csr_rvalid  <= 1'b0;
            csr.csr_illegal <= 1'b0;
        end else begin
            csr.csr_rvalid <= csr.csr_valid;
            if (csr.csr_valid) begin
                csr.csr_rdata   <= read_val;
                csr.csr_illegal <= ~legal;
            end else begin
                csr.csr_illegal <= 1'b0;
            end
            fflags <= fflags_next;
            frm    <= frm_next;
            // A state change wins over a simultaneous clear.
            if ((fflags_next != fflags) || (frm_next != frm)) begin
                dirty <= 1'b1;
            end else if (dirty_clear) begin
                dirty <= 1'b0;
            end
        end
    end

    fp_rm_resolve u_rm_resolve (
        .rm_in      (rm_in),
        .frm        (frm),
        .rm_out     (rm_out),
        .rm_illegal (rm_illegal)
    );

endmodule

// File: tb/tb_fp_csr.sv
// Directed, scoreboard-based bench for fp_csr with NPORTS = 2, XLEN = 32.
module tb_fp_csr;
    import fp_cons::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [1:0]  flag_valid;
    logic [9:0]  flag_data;
    logic [2:0]  rm_in;
    logic [2:0]  rm_out;
    logic        rm_illegal;
    logic        dirty;
    logic        dirty_clear;

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        exp_q[$];

    fp_csr_if #(.XLEN(32)) bus ();

    fp_csr #(.NPORTS(2), .XLEN(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .csr         (bus),
        .flag_valid  (flag_valid),
        .flag_data   (flag_data),
        .rm_in       (rm_in),
        .rm_out      (rm_out),
        .rm_illegal  (rm_illegal),
        .dirty       (dirty),
        .dirty_clear (dirty_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the response of the previous cycle's access is checked here.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rvalid", 32'(bus.csr_rvalid), 32'd1);
            chk("rdata", bus.csr_rdata, e.rdata);
            chk("illegal", 32'(bus.csr_illegal), 32'(e.ill));
        end else begin
            chk("rvalid_idle", 32'(bus.csr_rvalid), 32'd0);
        end
    endtask

    task automatic access(input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd, input logic [31:0] er,
                          input logic ei);
        exp_t e;
        bus.csr_valid = 1'b1;
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        e.rdata = er;
        e.ill   = ei;
        exp_q.push_back(e);
        tick();
        bus.csr_valid = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.csr_valid = 1'b0;
        bus.csr_addr  = '0;
        bus.csr_op    = '0;
        bus.csr_wdata = '0;
        flag_valid    = '0;
        flag_data     = '0;
        rm_in         = 3'b111;
        dirty_clear   = 1'b0;

        // Reset state
        #12;
        chk("rst_rdata", bus.csr_rdata, 32'h0);
        chk("rst_rvalid", 32'(bus.csr_rvalid), 32'h0);
        chk("rst_illegal", 32'(bus.csr_illegal), 32'h0);
        chk("rst_dirty", 32'(dirty), 32'h0);
        chk("rst_rm_out", 32'(rm_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // fcsr write 0xA5 then read back through each alias
        access(ADDR_FCSR, CSR_WRITE, 32'h0000_00A5, 32'h0, 1'b0);
        chk("dirty_after_wr", 32'(dirty), 32'h1);
        access(ADDR_FCSR, CSR_READ, 32'h0, 32'h0000_00A5, 1'b0);
        access(ADDR_FRM, CSR_READ, 32'h0, 32'h5, 1'b0);
        access(ADDR_FFLAGS, CSR_READ, 32'h0, 32'h5, 1'b0);
        chk("rm_dyn_101", 32'(rm_out), 32'h5);
        chk("rm_ill_dyn_101", 32'(rm_illegal), 32'h1);

        dirty_clear = 1'b1;
        tick();
        dirty_clear = 1'b0;
        chk("dirty_cleared", 32'(dirty), 32'h0);

        // Clear racing a port-1 flag: the flag survives
        access(ADDR_FFLAGS, CSR_WRITE, 32'h1, 32'h5, 1'b0);
        flag_valid = 2'b10;
        flag_data  = {5'b10000, 5'b00000};
        access(ADDR_FFLAGS, CSR_CLEAR, 32'h1F, 32'h1, 1'b0);
        flag_valid = 2'b00;
        flag_data  = '0;
        access(ADDR_FFLAGS, CSR_READ, 32'h0, 32'h10, 1'b0);
        chk("dirty_after_acc", 32'(dirty), 32'h1);

        // Upper write bits are ignored
        access(ADDR_FFLAGS, CSR_WRITE, 32'hFFFF_FFE0, 32'h10, 1'b0);
        access(ADDR_FFLAGS, CSR_READ, 32'h0, 32'h0, 1'b0);

        // Unstrobed data is ignored; both ports accumulate
        flag_valid = 2'b00;
        flag_data  = 10'h3FF;
        tick();
        flag_valid = 2'b11;
        flag_data  = {5'b01000, 5'b00010};
        tick();
        flag_valid = 2'b00;
        flag_data  = '0;
        access(ADDR_FFLAGS, CSR_READ, 32'h0, 32'h0A, 1'b0);

        // Rounding-mode resolution
        access(ADDR_FRM, CSR_WRITE, 32'h0000_00FA, 32'h5, 1'b0);
        chk("rm_dyn_010", 32'(rm_out), 32'h2);
        chk("rm_ill_010", 32'(rm_illegal), 32'h0);
        access(ADDR_FRM, CSR_SET, 32'h4, 32'h2, 1'b0);
        chk("rm_dyn_110", 32'(rm_out), 32'h6);
        chk("rm_ill_110", 32'(rm_illegal), 32'h1);
        rm_in = 3'b101;
        #1;
        chk("rm_static_101", 32'(rm_out), 32'h5);
        chk("rm_ill_static_101", 32'(rm_illegal), 32'h1);
        rm_in = 3'b011;
        #1;
        chk("rm_static_011", 32'(rm_out), 32'h3);
        chk("rm_ill_static_011", 32'(rm_illegal), 32'h0);
        rm_in = 3'b111;

        // fcsr clear hits both fields
        access(ADDR_FCSR, CSR_READ, 32'h0, 32'h0000_00CA, 1'b0);
        access(ADDR_FCSR, CSR_CLEAR, 32'h0000_00C2, 32'h0000_00CA, 1'b0);
        access(ADDR_FCSR, CSR_READ, 32'h0, 32'h08, 1'b0);

        // Illegal address leaves state alone
        dirty_clear = 1'b1;
        tick();
        dirty_clear = 1'b0;
        access(12'h004, CSR_WRITE, 32'hFF, 32'h0, 1'b1);
        chk("dirty_illegal", 32'(dirty), 32'h0);
        access(12'h000, CSR_READ, 32'h0, 32'h0, 1'b1);
        access(ADDR_FCSR, CSR_READ, 32'h0, 32'h08, 1'b0);

        // Reset in the middle of a write burst
        access(ADDR_FCSR, CSR_WRITE, 32'h0000_00E3, 32'h08, 1'b0);
        access(ADDR_FCSR, CSR_WRITE, 32'h0000_0061, 32'h0000_00E3, 1'b0);
        chk("pre_rst_rm_out", 32'(rm_out), 32'h3);
        bus.csr_valid = 1'b1;
        bus.csr_addr  = ADDR_FCSR;
        bus.csr_op    = CSR_WRITE;
        bus.csr_wdata = 32'h55;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rdata", bus.csr_rdata, 32'h0);
        chk("async_rvalid", 32'(bus.csr_rvalid), 32'h0);
        chk("async_illegal", 32'(bus.csr_illegal), 32'h0);
        chk("async_dirty", 32'(dirty), 32'h0);
        chk("async_rm_out", 32'(rm_out), 32'h0);
        @(posedge clock);
        #1;
        @(negedge clock);
        bus.csr_valid = 1'b0;
        reset = 1'b0;
        access(ADDR_FCSR, CSR_READ, 32'h0, 32'h0, 1'b0);
        chk("post_rst_dirty", 32'(dirty), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_csr.md
FP_CSR -- requirements
Module: fp_csr

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of FP retire ports reporting exception flags (1..4).
REQ-002 SHALL have parameter XLEN, default 32, CSR data width.
REQ-003 SHALL have port: clock  in  1  rising-edge clock.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: csr_valid  in  1  CSR access request this cycle.
REQ-006 SHALL have port: csr_addr  in  12  CSR address: fflags 12'h001, frm 12'h002, fcsr 12'h003.
REQ-007 SHALL have port: csr_op  in  2  access type: 00 read, 01 write, 10 set, 11 clear.
REQ-008 SHALL have port: csr_wdata  in  XLEN  write/set/clear operand.
REQ-009 SHALL have port: csr_rdata  out  XLEN  registered pre-update CSR value.
REQ-010 SHALL have port: csr_rvalid  out  1  one-cycle pulse qualifying csr_rdata/csr_illegal.
REQ-011 SHALL have port: csr_illegal  out  1  access to an address outside 001..003.
REQ-012 SHALL have port: flag_valid  in  NPORTS  per-port retire strobe.
REQ-013 SHALL have port: flag_data  in  NPORTS*5  per-port flags {NV,DZ,OF,UF,NX}, port i at [5i+4:5i].
REQ-014 SHALL have port: rm_in  in  3  instruction rounding-mode field.
REQ-015 SHALL have port: rm_out  out  3  resolved rounding mode, combinational.
REQ-016 SHALL have port: rm_illegal  out  1  resolved mode reserved, combinational.
REQ-017 SHALL have port: dirty  out  1  sticky FP-state-modified indicator.
REQ-018 SHALL have port: dirty_clear  in  1  clears dirty.

Function
REQ-019 SHALL hold state fflags[4:0] and frm[2:0]; fcsr read value = {XLEN-8 zeros, frm, fflags}.
REQ-020 SHALL return csr_rdata one cycle after csr_valid, holding the value from before that cycle's update; zero-extended; csr_rvalid high that cycle only.
REQ-021 SHALL compute the next value: write = operand; set = old | operand; clear = old & ~operand; read = old. Operand is wdata[4:0] for fflags, wdata[2:0] for frm, wdata[7:0] split frm=[7:5], fflags=[4:0] for fcsr.
REQ-022 SHALL ignore csr_wdata bits above the target field width.
REQ-023 SHALL, when an access is illegal, leave all state unchanged and return csr_rdata = 0 with csr_illegal = 1.
REQ-024 SHALL OR the flag_data of every port with flag_valid = 1 into fflags each cycle.
REQ-025 SHALL, when a CSR fflags/fcsr update and flag accumulation occur in the same cycle, set fflags_next = csr_result | accumulated flags (accumulated flags are never lost, even on clear).
REQ-026 SHALL resolve rm_out = frm when rm_in = 3'b111, otherwise rm_out = rm_in; resolution uses the current registered frm.
REQ-027 SHALL assert rm_illegal when rm_out is 3'b101, 3'b110 or 3'b111.
REQ-028 SHALL set dirty on any cycle where fflags or frm changes value; setting has priority over a simultaneous dirty_clear.
REQ-029 SHALL accept frm writes of reserved encodings 101..111 unchanged.
REQ-030 SHALL allow back-to-back accesses every cycle with no stall.

Reset
REQ-031 SHALL, on reset assertion, asynchronously clear fflags, frm, csr_rdata, csr_rvalid, csr_illegal and dirty to 0.
REQ-032 SHALL discard any access or flag strobe that coincides with reset; the first operation takes effect on the first edge after reset is deasserted.

Structure
REQ-033 SHALL take the CSR addresses, the csr_op encodings, the rounding-mode encodings (RNE 000, RTZ 001, RDN 010, RUP 011, RMM 100, DYN 111) and the flag bit positions (NV 4, DZ 3, OF 2, UF 1, NX 0) from the shared fp_cons package.
REQ-034 SHALL place rounding-mode resolution in one combinational sub-module, fp_rm_resolve.

Verification
REQ-035 SHALL cover: reset, then a write of fcsr with 32'h000000A5 -> next read of fcsr gives 32'h000000A5, frm = 3'b101, fflags = 5'b00101, dirty = 1.
REQ-036 SHALL cover: fflags = 5'b00001, clear of fflags with 5'h1F in the same cycle that port 1 reports 5'b10000 -> csr_rdata = 32'h1, then fflags = 5'b10000.
REQ-037 SHALL cover: NPORTS = 2, both ports strobe in one cycle (5'b00010 and 5'b01000) -> fflags = 5'b01010.
REQ-038 SHALL cover: frm = 3'b010, rm_in = 3'b111 -> rm_out = 3'b010 and rm_illegal = 0; with frm = 3'b110 -> rm_illegal = 1; rm_in = 3'b101 -> rm_illegal = 1.
REQ-039 SHALL cover: access to 12'h004 with op write -> csr_illegal = 1, csr_rdata = 0, state unchanged.
REQ-040 SHALL cover: reset asserted in the middle of a burst of writes -> all outputs are 0 immediately, with no clock edge needed.
